// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, mfc0/mtc0 access and the exception/interrupt flush request.
// Optional Count/Compare timer enabled by defining CP0_COUNT_EN.
module cp0_unit #(
    parameter logic [31:0] PRID_VAL  = 32'h0000_0007,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] M_PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPCOut,
    output logic        Req
);

    // The handler entry is consumed by the pipeline registers; only its alignment matters here.
    if (EXC_ENTRY[1:0] != 2'b00) begin : g_bad_entry
        $error("EXC_ENTRY must be word aligned");
    end

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic [5:0]  hw_eff;
    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_al;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        mtc0_ok;

`ifdef CP0_COUNT_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_flag;

    assign hw_eff = {HWInt[5] | timer_flag, HWInt[4:0]};
`else
    assign hw_eff = HWInt;
`endif

    assign int_req   = (|(hw_eff & im)) & ie & ~exl;
    assign exc_req   = (ExcCodeIn != 5'd0) & ~exl;
    assign Req       = int_req | exc_req;
    assign mtc0_ok   = WE & ~Req;
    assign pc_al     = M_PC & 32'hFFFF_FFFC;
    assign sr_val    = {16'b0, im, 8'b0, exl, ie};
    assign cause_val = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
    assign EPCOut    = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= hw_eff;
            if (Req) begin
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : ExcCodeIn;
                bd       <= BDIn;
                epc      <= BDIn ? (pc_al - 32'd4) : pc_al;
            end else begin
                if (WE && A2 == 5'd12) begin
                    im  <= DIn[15:10];
                    exl <= DIn[1];
                    ie  <= DIn[0];
                end
                if (WE && A2 == 5'd14) epc <= {DIn[31:2], 2'b00};
                // eret overrides an SR write landing in the same cycle
                if (EXLClr) exl <= 1'b0;
            end
        end
    end

`ifdef CP0_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            compare    <= '0;
            timer_flag <= 1'b0;
        end else begin
            if (count == compare && compare != 32'd0) timer_flag <= 1'b1;
            if (mtc0_ok && A2 == 5'd11) begin
                compare    <= DIn;
                timer_flag <= 1'b0;
            end
            if (mtc0_ok && A2 == 5'd9) count <= DIn;
            else                       count <= count + 32'd1;
        end
    end
`endif

    always_comb begin
        DOut = 32'd0;
        case (A1)
            5'd12:   DOut = sr_val;
            5'd13:   DOut = cause_val;
            5'd14:   DOut = epc;
            5'd15:   DOut = PRID_VAL;
`ifdef CP0_COUNT_EN
            5'd9:    DOut = count;
            5'd11:   DOut = compare;
`endif
            default: DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit; the timer scenario runs when CP0_COUNT_EN is defined.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a1, a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] m_pc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] dout;
    logic [31:0] epc_out;
    logic        req;
    int          total = 0;
    int          bad = 0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(a1), .A2(a2), .DIn(din), .WE(we),
        .M_PC(m_pc), .BDIn(bd_in), .ExcCodeIn(exc_code_in), .HWInt(hw_int),
        .EXLClr(exl_clr), .DOut(dout), .EPCOut(epc_out), .Req(req)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        a1 = 5'd12; #1;
        total++; if (dout !== 32'd0) begin bad++; $display("FAIL reset_sr: got %h want %h", dout, 32'd0); end
        a1 = 5'd13; #1;
        total++; if (dout !== 32'd0) begin bad++; $display("FAIL reset_cause: got %h want %h", dout, 32'd0); end
        a1 = 5'd14; #1;
        total++; if (dout !== 32'd0) begin bad++; $display("FAIL reset_epc: got %h want %h", dout, 32'd0); end
        total++; if (epc_out !== 32'd0) begin bad++; $display("FAIL reset_epcout: got %h want %h", epc_out, 32'd0); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", req); end
        a1 = 5'd15; #1;
        total++; if (dout !== 32'h7) begin bad++; $display("FAIL prid: got %h want %h", dout, 32'h7); end
    endtask

    task automatic test_masked_int();
        we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
        step();
        we = 1'b0; a1 = 5'd12; #1;
        total++; if (dout !== 32'h0000_0401) begin bad++; $display("FAIL int_sr_write: got %h want %h", dout, 32'h401); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL int_req_idle: got %b want 0", req); end
        hw_int = 6'b000001; m_pc = 32'h3010; bd_in = 1'b0; #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL int_req: got %b want 1", req); end
        step();
        a1 = 5'd14; #1;
        total++; if (dout !== 32'h3010) begin bad++; $display("FAIL int_epc: got %h want %h", dout, 32'h3010); end
        total++; if (epc_out !== 32'h3010) begin bad++; $display("FAIL int_epcout: got %h want %h", epc_out, 32'h3010); end
        a1 = 5'd12; #1;
        total++; if (dout !== 32'h0000_0403) begin bad++; $display("FAIL int_sr_exl: got %h want %h", dout, 32'h403); end
        a1 = 5'd13; #1;
        total++; if (dout !== 32'h0000_0400) begin bad++; $display("FAIL int_cause: got %h want %h", dout, 32'h400); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL int_req_held: got %b want 0", req); end
    endtask

    task automatic test_eret();
        exl_clr = 1'b1; #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL eret_req_during: got %b want 0", req); end
        step();
        exl_clr = 1'b0; a1 = 5'd12; #1;
        total++; if (dout !== 32'h0000_0401) begin bad++; $display("FAIL eret_sr: got %h want %h", dout, 32'h401); end
        total++; if (req !== 1'b1) begin bad++; $display("FAIL eret_req_again: got %b want 1", req); end
        reset = 1'b1; we = 1'b1; a2 = 5'd14; din = 32'h5555; exc_code_in = 5'd2;
        step();
        reset = 1'b0; we = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0;
        a1 = 5'd12; #1;
        total++; if (dout !== 32'd0) begin bad++; $display("FAIL rst_req_sr: got %h want %h", dout, 32'd0); end
        a1 = 5'd13; #1;
        total++; if (dout !== 32'd0) begin bad++; $display("FAIL rst_req_cause: got %h want %h", dout, 32'd0); end
        total++; if (epc_out !== 32'd0) begin bad++; $display("FAIL rst_req_epc: got %h want %h", epc_out, 32'd0); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL rst_req_req: got %b want 0", req); end
    endtask

    task automatic test_exc_delay_slot();
        exc_code_in = 5'd10; m_pc = 32'h3024; bd_in = 1'b1; #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL exc_req: got %b want 1", req); end
        step();
        exc_code_in = 5'd0; bd_in = 1'b0; #1;
        total++; if (epc_out !== 32'h3020) begin bad++; $display("FAIL exc_epc: got %h want %h", epc_out, 32'h3020); end
        a1 = 5'd13; #1;
        total++; if (dout !== 32'h8000_0028) begin bad++; $display("FAIL exc_cause: got %h want %h", dout, 32'h80000028); end
        exc_code_in = 5'd3; #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL exc_masked_by_exl: got %b want 0", req); end
        exc_code_in = 5'd0; exl_clr = 1'b1;
        step();
        exl_clr = 1'b0;
    endtask

    task automatic test_priority();
        we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
        step();
        hw_int = 6'b000001; exc_code_in = 5'd4; a2 = 5'd14; din = 32'h1234;
        m_pc = 32'h5008; bd_in = 1'b0; #1;
        total++; if (req !== 1'b1) begin bad++; $display("FAIL prio_req: got %b want 1", req); end
        step();
        we = 1'b0; exc_code_in = 5'd0; a1 = 5'd13; #1;
        total++; if (dout !== 32'h0000_0400) begin bad++; $display("FAIL prio_cause: got %h want %h", dout, 32'h400); end
        total++; if (epc_out !== 32'h5008) begin bad++; $display("FAIL prio_epc_suppress: got %h want %h", epc_out, 32'h5008); end
        hw_int = 6'd0;
    endtask

    task automatic test_width();
        exl_clr = 1'b1;
        step();
        exl_clr = 1'b0; exc_code_in = 5'd1; m_pc = 32'h0; bd_in = 1'b1;
        step();
        exc_code_in = 5'd0; bd_in = 1'b0; a1 = 5'd13; #1;
        total++; if (epc_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_epc: got %h want %h", epc_out, 32'hFFFFFFFC); end
        total++; if (dout !== 32'h8000_0004) begin bad++; $display("FAIL wrap_cause: got %h want %h", dout, 32'h80000004); end
    endtask

    task automatic test_mtc0_fields();
        exl_clr = 1'b1;
        step();
        we = 1'b1; a2 = 5'd12; din = 32'hFFFF_FFFF;
        step();
        exl_clr = 1'b0; a1 = 5'd12; we = 1'b0; #1;
        total++; if (dout !== 32'h0000_FC01) begin bad++; $display("FAIL sr_mask_eret: got %h want %h", dout, 32'hFC01); end
        we = 1'b1; a2 = 5'd14; din = 32'h1237; a1 = 5'd14; #1;
        total++; if (dout !== 32'hFFFF_FFFC) begin bad++; $display("FAIL no_bypass: got %h want %h", dout, 32'hFFFFFFFC); end
        step();
        total++; if (dout !== 32'h1234) begin bad++; $display("FAIL epc_write: got %h want %h", dout, 32'h1234); end
        a2 = 5'd13; din = 32'hFFFF_FFFF;
        step();
        a1 = 5'd13; #1;
        total++; if (dout !== 32'h8000_0004) begin bad++; $display("FAIL cause_ro: got %h want %h", dout, 32'h80000004); end
        a2 = 5'd15;
        step();
        a1 = 5'd15; #1;
        total++; if (dout !== 32'h7) begin bad++; $display("FAIL prid_ro: got %h want %h", dout, 32'h7); end
`ifndef CP0_COUNT_EN
        a2 = 5'd9;
        step();
        a1 = 5'd9; #1;
        total++; if (dout !== 32'd0) begin bad++; $display("FAIL reg9_absent: got %h want %h", dout, 32'd0); end
`endif
        we = 1'b0; a1 = 5'd3; #1;
        total++; if (dout !== 32'd0) begin bad++; $display("FAIL unimpl_read: got %h want %h", dout, 32'd0); end
    endtask

`ifdef CP0_COUNT_EN
    task automatic test_count();
        we = 1'b1; a2 = 5'd12; din = 32'h0000_8001;
        step();
        a2 = 5'd11; din = 32'd5;
        step();
        a2 = 5'd9; din = 32'd0;
        step();
        we = 1'b0;
        for (int i = 0; i < 5; i++) step();
        a1 = 5'd9; #1;
        total++; if (dout !== 32'd5) begin bad++; $display("FAIL count_val: got %h want %h", dout, 32'd5); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL timer_early: got %b want 0", req); end
        step();
        total++; if (req !== 1'b1) begin bad++; $display("FAIL timer_req: got %b want 1", req); end
        step();
        a1 = 5'd13; #1;
        total++; if (dout !== 32'h0000_8000) begin bad++; $display("FAIL timer_ip: got %h want %h", dout, 32'h8000); end
        we = 1'b1; a2 = 5'd11; din = 32'd0; exl_clr = 1'b1;
        step();
        we = 1'b0; exl_clr = 1'b0; #1;
        total++; if (req !== 1'b0) begin bad++; $display("FAIL timer_clear: got %b want 0", req); end
    endtask
`endif

    initial begin
        reset = 1'b1; a1 = '0; a2 = '0; din = '0; we = 1'b0; m_pc = '0;
        bd_in = 1'b0; exc_code_in = '0; hw_int = '0; exl_clr = 1'b0;
        test_reset();
        test_masked_int();
        test_eret();
        test_exc_delay_slot();
        test_priority();
        test_width();
        test_mtc0_fields();
`ifdef CP0_COUNT_EN
        test_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor 0 for the pipelined MIPS core. Sits at the M stage and initiates `Req`, the exception/interrupt flush that every pipeline register consumes: they clear, and the M/W register loads PC 0x00004180.
- Holds SR, Cause, EPC and PRId. Serves mfc0 reads and mtc0 writes, and clears EXL on eret.

Parameters:
- PRID_VAL, 32'h0000_0007, read-only value returned for register 15.
- EXC_ENTRY, 32'h0000_4180, handler entry address. Informational only; the pipeline registers use it, this block does not drive it.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- A1  input  5  mfc0 read register number.
- A2  input  5  mtc0 write register number.
- DIn  input  32  mtc0 write data.
- WE  input  1  mtc0 write enable (M stage).
- M_PC  input  32  PC of the instruction currently in M.
- BDIn  input  1  M instruction is in a branch delay slot.
- ExcCodeIn  input  5  exception code of the M instruction; 0 means none.
- HWInt  input  6  external hardware interrupt lines [5:0].
- EXLClr  input  1  eret in M; clear EXL.
- DOut  output  32  combinational read data for A1.
- EPCOut  output  32  current EPC register, for eret target.
- Req  output  1  combinational flush/exception request.

Behaviour:
- SR (reg 12) fields:
  - IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - mtc0 writes only these bits.
- Cause (reg 13) fields:
  - BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - Cause is not mtc0-writable; writes to 13 are ignored.
- EPC (reg 14):
  - mtc0 writes it as {DIn[31:2],2'b00}.
- PRId (reg 15):
  - Reads PRID_VAL; writes are ignored.
- Unimplemented register numbers read 0 and ignore writes.
- Request logic:
  - IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
  - Req = IntReq | ExcReq. Purely combinational, zero latency.
- Cause.IP <= HWInt every cycle, unconditionally, except under reset.
- On posedge with Req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= IntReq ? 5'd0 : ExcCodeIn. Interrupt has priority over a simultaneous exception.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? ({M_PC[31:2],2'b00} - 4) : {M_PC[31:2],2'b00}.
  - Any mtc0 (WE) in the same cycle is suppressed. The instruction is flushed.
- On posedge with Req=0:
  - WE=1 performs the mtc0 write to A2.
  - EXLClr=1 sets SR.EXL <= 0.
  - If WE targets SR and EXLClr are both set, the write occurs first, then EXL is forced 0.
- EXLClr together with Req=1: Req wins and EXL stays 1. This case is reachable only when EXL was 0.
- DOut reads the register state before the current edge; there is no write bypass.
  - An mtc0 in M followed by an mfc0 in the next cycle sees the new value.
- EPCOut = EPC register directly. No bypass of a same-cycle mtc0.
- Reset: SR=0, Cause=0, EPC=0.
  - Consequently Req=0, DOut=0 for registers 12/13/14, and EPCOut=0.
  - Reset has priority over Req, WE and EXLClr in the same cycle.
- Width rules: EPC arithmetic is 32-bit modulo. M_PC=0 with BD=1 wraps to 32'hFFFF_FFFC; no trap.

Optional Feature:
- Macro CP0_COUNT_EN.
- Defined:
  - Adds Count (reg 9), incrementing by 1 every non-reset cycle and wrapping at 2^32.
  - Adds Compare (reg 11).
  - mtc0 to Count loads DIn, and that cycle's increment is skipped.
  - mtc0 to Compare loads DIn and clears the timer pending flag.
  - The timer flag sets on the edge where Count == Compare and Compare != 0.
  - The timer flag is ORed into HWInt[5] for IP and IntReq.
  - Reset clears Count, Compare and the flag.
- Undefined: registers 9 and 11 read 0 and ignore writes; HWInt[5] is used as-is.

Test Plan:
- Reset, then read: assert reset for 1 cycle, then A1=12/13/14 -> DOut=0, EPCOut=0, Req=0.
- Masked interrupt:
  - mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001, M_PC=32'h3010, BDIn=0 -> Req=1 in that cycle.
  - Next cycle: EPC=32'h3010, SR.EXL=1, Cause.ExcCode=0, Cause.IP=1, and Req=0 while HWInt is held.
- Exception in delay slot: SR=0, ExcCodeIn=5'd10, M_PC=32'h3024, BDIn=1 -> Req=1; next cycle EPC=32'h3020, Cause=32'h8000_0028.
- Priority and suppression: with IntReq=1, ExcCodeIn=4 and WE=1 to EPC with DIn=32'h1234 -> ExcCode=0, and EPC=M_PC rather than 32'h1234.
- eret: with EXL=1, pulse EXLClr -> next cycle SR.EXL=0, Req reasserts if HWInt is still pending; simultaneous reset with Req=1 -> all registers 0.
- CP0_COUNT_EN: mtc0 Compare=5 and Count=0 -> on the 5th cycle, Cause.IP[15]=1 and Req=1 if IM[15]=IE=1; mtc0 Compare clears the flag.
